// File: rtl/mux_sel_scanner_if.sv
// Handshake/bus bundle between the scan requester (plus the mux it observes) and
// the select scanner.
interface mux_sel_scanner_if #(
    parameter int unsigned SEL_W = 2
);
    localparam int unsigned N = 1 << SEL_W;

    logic             start;
    logic             y_in;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [N-1:0]     word;

    // Requester side: issues start and returns the mux output for the current select.
    modport master (
        output start,
        output y_in,
        input  sel,
        input  busy,
        input  done,
        input  word
    );

    // Scanner side.
    modport slave (
        input  start,
        input  y_in,
        output sel,
        output busy,
        output done,
        output word
    );
endinterface

// File: rtl/mux_sel_scanner.sv
// Steps an N:1 mux select through every input, holds each select for DWELL cycles,
// and assembles the Y sample taken on the last dwell cycle into a parallel word.
module mux_sel_scanner #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_scanner_if.slave    bus
);
    localparam int unsigned N     = 1 << SEL_W;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [N-1:0]     word_q,  word_d;

    // State and registered outputs; reset mid-scan abandons the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            word_q  <= word_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        word_d  = word_q;

        unique case (state_q)
            ST_IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_SCAN: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Last dwell cycle: Y has been settled for DWELL full cycles.
                    cnt_d         = '0;
                    word_d[sel_q] = bus.y_in;
                    if (sel_q == SEL_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.word = word_q;

endmodule
